// File: rtl/if_stage_if.sv
// Instruction RAM port bundle between the fetch stage (master) and a
// synchronous, 1-cycle-latency instruction RAM (slave).
interface if_stage_if #(
    parameter int IADR_W = 12
) ();
    logic              imem_re;
    logic [IADR_W-1:0] imem_radr;
    logic [31:0]       imem_rdata;

    modport master (output imem_re, output imem_radr, input imem_rdata);
    modport slave  (input imem_re, input imem_radr, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues PC reads to a synchronous instruction RAM,
// hides the RAM latency across stalls with a one-entry hold buffer, kills on flush.
module if_stage #(
    parameter int          IADR_W   = 12,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         flush,
    input  logic         cpu_stat_pc,
    input  logic [29:0]  pc,
    if_stage_if.master   imem,
    output logic [31:0]  inst_id,
    output logic [29:0]  pc_id,
    output logic         inst_vld_id,
    output logic         fault_id
);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    state_t      state_reg, state_next;
    logic        issue;
    logic        addr_fault;
    logic        f1_vld_reg, f1_fault_reg;
    logic [29:0] f1_pc_reg;
    logic        hold_vld_reg;
    logic [31:0] hold_inst_reg;
    logic [31:0] f1_data;
    logic        out_load, hold_capture, hold_clear;
    logic [31:0] inst_id_reg;
    logic [29:0] pc_id_reg;
    logic        inst_vld_id_reg, fault_id_reg;

    // Any PC bit above the RAM word-address range marks the fetch as faulting.
    generate
        if (IADR_W < 30) begin : g_fault
            assign addr_fault = |pc[29:IADR_W];
        end else begin : g_nofault
            assign addr_fault = 1'b0;
        end
    endgenerate

    assign issue          = cpu_stat_pc & ~stall & ~flush;
    assign imem.imem_re   = issue;
    assign imem.imem_radr = pc[IADR_W-1:0];

    // Faulting or empty slots never expose raw RAM data.
    always_comb begin
        f1_data = NOP_INST;
        if (hold_vld_reg)
            f1_data = hold_inst_reg;
        else if (f1_vld_reg && !f1_fault_reg)
            f1_data = imem.imem_rdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= RUN;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = RUN;
        end else begin
            case (state_reg)
                RUN:     if (stall && f1_vld_reg) state_next = HOLD;
                HOLD:    if (!stall)              state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    always_comb begin
        out_load     = ~flush & ~stall;
        hold_capture = ~flush & stall & f1_vld_reg & (state_reg == RUN);
        hold_clear   = flush | (~stall & (state_reg == HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            f1_vld_reg   <= 1'b0;
            f1_fault_reg <= 1'b0;
        end else if (!stall) begin
            f1_vld_reg   <= issue;
            f1_fault_reg <= issue & addr_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (!stall && issue)
            f1_pc_reg <= pc;
    end

    // The RAM data is only present on the first stalled cycle, so it is captured there.
    always_ff @(posedge clk) begin
        if (rst || hold_clear)
            hold_vld_reg <= 1'b0;
        else if (hold_capture)
            hold_vld_reg <= 1'b1;
        if (hold_capture)
            hold_inst_reg <= f1_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inst_id_reg     <= NOP_INST;
            pc_id_reg       <= 30'd0;
            inst_vld_id_reg <= 1'b0;
            fault_id_reg    <= 1'b0;
        end else if (flush) begin
            inst_id_reg     <= NOP_INST;
            inst_vld_id_reg <= 1'b0;
            fault_id_reg    <= 1'b0;
        end else if (out_load) begin
            inst_id_reg     <= f1_data;
            pc_id_reg       <= f1_pc_reg;
            inst_vld_id_reg <= f1_vld_reg;
            fault_id_reg    <= f1_vld_reg & f1_fault_reg;
        end
    end

    assign inst_id     = inst_id_reg;
    assign pc_id       = pc_id_reg;
    assign inst_vld_id = inst_vld_id_reg;
    assign fault_id    = fault_id_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: cycle table, hand sequences for HOLD corner cases, and
// a queue scoreboard checking every cycle's decode-side outputs.
module tb_if_stage;
    localparam int          IADR_W = 12;
    localparam logic [31:0] NOP    = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, flush = 1'b0, cpu_stat_pc = 1'b0;
    logic [29:0] pc = 30'd0;
    logic [31:0] inst_id;
    logic [29:0] pc_id;
    logic        inst_vld_id, fault_id;

    int checks = 0;
    int errors = 0;

    if_stage_if #(.IADR_W(IADR_W)) imem ();

    if_stage #(.IADR_W(IADR_W), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .cpu_stat_pc(cpu_stat_pc), .pc(pc), .imem(imem.master),
        .inst_id(inst_id), .pc_id(pc_id), .inst_vld_id(inst_vld_id), .fault_id(fault_id)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:(1<<IADR_W)-1];
    always @(posedge clk) if (imem.imem_re) imem.imem_rdata <= mem[imem.imem_radr];

    typedef struct {
        logic [31:0] inst;
        logic [29:0] pc;
        logic        fault;
    } exp_t;

    function automatic exp_t model_fetch(logic [29:0] p);
        exp_t e;
        e.pc    = p;
        e.fault = |p[29:IADR_W];
        e.inst  = e.fault ? NOP : mem[p[IADR_W-1:0]];
        return e;
    endfunction

    // Scoreboard: issues enter at the edge they are accepted, leave when the output register loads.
    exp_t        sbq[$];
    logic        armed = 1'b0;
    logic        m_vld = 1'b0, m_fault = 1'b0;
    logic [31:0] m_inst = NOP;
    logic [29:0] m_pc = 30'd0;

    always @(posedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            m_vld = 1'b0; m_inst = NOP; m_pc = 30'd0; m_fault = 1'b0;
            armed = 1'b1;
        end else if (flush) begin
            sbq.delete();
            m_vld = 1'b0; m_inst = NOP; m_fault = 1'b0;
        end else if (!stall) begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                m_vld = 1'b1; m_inst = e.inst; m_pc = e.pc; m_fault = e.fault;
            end else begin
                m_vld = 1'b0; m_inst = NOP; m_fault = 1'b0;
            end
            if (cpu_stat_pc) sbq.push_back(model_fetch(pc));
        end
    end

    always @(negedge clk) begin
        logic exp_re;
        if (armed) begin
            checks++;
            if (inst_vld_id !== m_vld || inst_id !== m_inst || fault_id !== m_fault ||
                (m_vld && pc_id !== m_pc)) begin
                errors++;
                $display("FAIL sb_out t=%0t got vld=%b inst=%h pc=%h flt=%b want vld=%b inst=%h pc=%h flt=%b",
                         $time, inst_vld_id, inst_id, pc_id, fault_id, m_vld, m_inst, m_pc, m_fault);
            end
            exp_re = cpu_stat_pc & ~stall & ~flush;
            checks++;
            if (imem.imem_re !== exp_re || (exp_re && imem.imem_radr !== pc[IADR_W-1:0])) begin
                errors++;
                $display("FAIL sb_re t=%0t got re=%b radr=%h want re=%b radr=%h",
                         $time, imem.imem_re, imem.imem_radr, exp_re, pc[IADR_W-1:0]);
            end
        end
    end

    typedef struct {
        logic        stall, flush, csp;
        logic [29:0] pc;
        logic        exp_re, exp_vld;
        logic [31:0] exp_inst;
        logic [29:0] exp_pc;
        logic        exp_fault;
    } vec_t;

    function automatic vec_t mk(logic s, logic f, logic c, logic [29:0] p, logic re,
                                logic v, logic [31:0] i, logic [29:0] op, logic flt);
        vec_t r;
        r.stall = s; r.flush = f; r.csp = c; r.pc = p; r.exp_re = re;
        r.exp_vld = v; r.exp_inst = i; r.exp_pc = op; r.exp_fault = flt;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic r, logic s, logic f, logic c, logic [29:0] p);
        rst = r; stall = s; flush = f; cpu_stat_pc = c; pc = p;
    endtask

    task automatic chk_out(string name, logic v, logic [31:0] i, logic [29:0] p, logic flt);
        checks++;
        if (inst_vld_id !== v || inst_id !== i || fault_id !== flt || (v && pc_id !== p)) begin
            errors++;
            $display("FAIL %s got vld=%b inst=%h pc=%h flt=%b want vld=%b inst=%h pc=%h flt=%b",
                     name, inst_vld_id, inst_id, pc_id, fault_id, v, i, p, flt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        logic [IADR_W-1:0] radr_exp;

        for (int i = 0; i < (1 << IADR_W); i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[5] = 32'd55;

        // Each row: inputs for one cycle, imem_re that cycle, outputs after its closing edge.
        vecs.push_back(mk(0,0,1,30'd0,        1, 0,NOP,          30'd0,        0));
        vecs.push_back(mk(0,0,1,30'd1,        1, 1,32'd11,       30'd0,        0));
        vecs.push_back(mk(0,0,1,30'd2,        1, 1,32'd22,       30'd1,        0));
        vecs.push_back(mk(0,0,1,30'd5,        1, 1,32'd33,       30'd2,        0));
        vecs.push_back(mk(1,0,1,30'd6,        0, 1,32'd33,       30'd2,        0));
        vecs.push_back(mk(1,0,1,30'd6,        0, 1,32'd33,       30'd2,        0));
        vecs.push_back(mk(1,0,1,30'd6,        0, 1,32'd33,       30'd2,        0));
        vecs.push_back(mk(0,0,1,30'd6,        1, 1,32'd55,       30'd5,        0));
        vecs.push_back(mk(0,0,1,30'd7,        1, 1,32'h10000006, 30'd6,        0));
        vecs.push_back(mk(0,1,1,30'd8,        0, 0,NOP,          30'd0,        0));
        vecs.push_back(mk(0,0,1,30'd40,       1, 0,NOP,          30'd0,        0));
        vecs.push_back(mk(0,0,0,30'd40,       0, 1,32'h10000028, 30'd40,       0));
        vecs.push_back(mk(0,0,1,30'h1000,     1, 0,NOP,          30'd0,        0));
        vecs.push_back(mk(0,0,0,30'h1000,     0, 1,NOP,          30'h1000,     1));
        vecs.push_back(mk(0,0,1,30'h3FFFFFFF, 1, 0,NOP,          30'd0,        0));
        vecs.push_back(mk(0,0,0,30'h3FFFFFFF, 0, 1,NOP,          30'h3FFFFFFF, 1));
        vecs.push_back(mk(0,0,0,30'd0,        0, 0,NOP,          30'd0,        0));

        drive(1,0,0,0,30'd0);
        tick(); tick();
        chk_out("reset", 1'b0, NOP, 30'd0, 1'b0);
        checks++;
        if (pc_id !== 30'd0) begin
            errors++;
            $display("FAIL reset_pc got %h want 0", pc_id);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(1'b0, v.stall, v.flush, v.csp, v.pc);
            #1;
            radr_exp = v.pc[IADR_W-1:0];
            checks++;
            if (imem.imem_re !== v.exp_re || (v.exp_re && imem.imem_radr !== radr_exp)) begin
                errors++;
                $display("FAIL vec%0d_re got re=%b radr=%h want re=%b radr=%h",
                         i, imem.imem_re, imem.imem_radr, v.exp_re, radr_exp);
            end
            @(posedge clk); #1;
            chk_out($sformatf("vec%0d_out", i), v.exp_vld, v.exp_inst, v.exp_pc, v.exp_fault);
        end

        // Flush together with stall while the hold buffer is occupied.
        drive(0,0,0,1,30'd5); tick();
        drive(0,1,0,1,30'd6); tick();
        drive(0,1,1,1,30'd6); tick();
        chk_out("flush_in_hold", 1'b0, NOP, 30'd0, 1'b0);
        drive(0,0,0,0,30'd6); tick();
        chk_out("post_flush_release", 1'b0, NOP, 30'd0, 1'b0);
        drive(0,0,0,1,30'd2); tick();
        drive(0,0,0,0,30'd2); tick();
        chk_out("post_flush_fetch", 1'b1, 32'd33, 30'd2, 1'b0);

        // Reset while HOLD is active with a valid instruction on the output.
        drive(0,0,0,1,30'd5); tick();
        drive(0,0,0,1,30'd2); tick();
        chk_out("pre_rst_out", 1'b1, 32'd55, 30'd5, 1'b0);
        drive(0,1,0,1,30'd1); tick();
        drive(1,1,0,1,30'd1); tick();
        chk_out("rst_in_hold", 1'b0, NOP, 30'd0, 1'b0);
        checks++;
        if (pc_id !== 30'd0) begin
            errors++;
            $display("FAIL rst_in_hold_pc got %h want 0", pc_id);
        end
        drive(0,0,0,0,30'd1); tick();
        chk_out("post_rst_release", 1'b0, NOP, 30'd0, 1'b0);
        drive(0,0,0,1,30'd1); tick();
        drive(0,0,0,0,30'd1); tick();
        chk_out("post_rst_fetch", 1'b1, 32'd22, 30'd1, 1'b0);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
